axi_pix_packer: RTL and testbench
=================================

# axi_pix_packer

Parametrised pixel-to-AXI-word packer for the VDMA write path (mm_tras side). It packs a stream of IDSIZE-bit pixels into ODSIZE-bit memory words, low pixel first. Unlike the fixed-ratio packer, it handles widths that do not divide the word (e.g. 24 into 256), so pixels straddle word boundaries. It adds output backpressure, a partial-word flush at end of line with byte strobes, and a synchronous clear.

## Interface
- IDSIZE, 24: pixel width in bits, 1..ODSIZE.
- ODSIZE, 256: output word width in bits, a multiple of 8.
- clock  in  1: sole clock, rising edge.
- rst  in  1: asynchronous reset, active-high.
- clear  in  1: synchronous discard of residue, output register and FLUSH state; highest priority after rst.
- iwr_en  in  1: input pixel valid.
- idata  in  IDSIZE: pixel data.
- ilast  in  1: marks the last pixel of a line; qualified by iwr_en.
- iready  out  1: input can be accepted; defined as (state==RUN) && (!owr_en || oready).
- owr_en  out  1: output word valid.
- oready  in  1: downstream accepts the word.
- odata  out  ODSIZE: packed word; first pixel occupies bits [IDSIZE-1:0].
- ostrb  out  ODSIZE/8: byte strobes for odata.
- olast  out  1: final word of a line.

## Operation
- Internal state:
  - bit pointer ptr, range 0..ODSIZE-1, reset 0.
  - accumulator acc, ODSIZE bits, reset 0.
  - FSM state RUN or FLUSH, reset RUN.
  - output register {odata, ostrb, olast, owr_en}.
- Accept: iwr_en && iready.
- On accept with sum = ptr + IDSIZE:
  - sum < ODSIZE and !ilast: write idata into acc at ptr; ptr <= sum.
  - sum < ODSIZE and ilast: emit acc|idata<<ptr, ostrb = ceil(sum/8) low bits set, olast=1; ptr<=0; acc<=0.
  - sum == ODSIZE: emit the full word, ostrb all ones, olast = ilast; ptr<=0; acc<=0.
  - sum > ODSIZE: emit the full word (low ODSIZE-ptr bits of idata fill the top), ostrb all ones, olast=0.
    - The remaining r = sum-ODSIZE high bits of idata move to acc[r-1:0]; ptr <= r.
    - If ilast: state <= FLUSH.
- FLUSH:
  - iready = 0.
  - When !owr_en || oready: emit acc, ostrb = ceil(ptr/8) low bits set, olast=1; ptr<=0; acc<=0; state<=RUN.
- Output register:
  - Emit loads odata/ostrb/olast and sets owr_en=1.
  - owr_en clears on oready when nothing new is emitted in the same cycle.
  - Emit and oready in the same cycle: the register is replaced and owr_en stays 1. No bubble, no loss.
- Bits of odata above the valid bits of a partial word are 0.
- clear: ptr<=0, acc<=0, owr_en<=0, olast<=0, state<=RUN. An input presented in the same cycle is dropped.
- An illegal IDSIZE (0 or >ODSIZE) or a non-byte-multiple ODSIZE is a fatal elaboration error.

## Timing
- Reset values: owr_en=0, odata=0, ostrb=0, olast=0, ptr=0, state=RUN.
- iready is combinational and reads 1 once rst deasserts; inputs are ignored while rst is high.
- Latency: a word becomes visible (owr_en=1) on the cycle after the accept that completes it.
- FLUSH residue word: visible one cycle after the FLUSH entry cycle if oready; otherwise after the stall clears.
- Throughput: one pixel per cycle while oready=1. A single-cycle iready=0 occurs only for an ilast overflow (FLUSH).
- Handshake rules:
  - odata/ostrb/olast are held stable while owr_en && !oready.
  - iready=0 whenever the output register is occupied and oready=0.
- ptr arithmetic uses clog2(ODSIZE)+1 bits so that sum never wraps.

## Test plan
- 24-bit into 256, pixels 0..31, no ilast, oready=1 -> 3 words, ostrb=all ones, olast=0.
  - word0 bits[23:0]=0, word0 bits[255:240]=pixel10[15:0].
  - word2 bits[255:232]=31.
  - ptr=0 after the run.
- 24-bit, pixels 1..11, ilast on the 11th -> word0 full (olast=0), then FLUSH -> word1 odata[7:0]=11>>16=0, ostrb=0x00000001, olast=1.
  - iready=0 for exactly one cycle.
- 32-bit, 8 pixels, ilast on the 8th -> one word, ostrb all ones, olast=1, FSM never enters FLUSH.
  - 3 pixels with ilast -> ostrb=0x00000FFF, odata[255:96]=0.
- Backpressure: 24-bit continuous input, oready low for 5 cycles after the first word -> iready low for those cycles.
  - Word held stable; all 32 pixels recovered in order once oready returns.
- Emit coincident with oready: a 32-bit stream with oready=1 -> owr_en stays high on back-to-back words, no duplication or drop.
- rst asserted mid-line (ptr=16) and clear asserted mid-FLUSH -> outputs return to their reset values immediately.
  - The next line starts at odata bit 0 with no stale residue.

Source files
------------

// File: rtl/axi_pix_packer.sv
// Packs IDSIZE-bit pixels into ODSIZE-bit words, low pixel first. Pixels may straddle
// word boundaries; end of line flushes a partial word with byte strobes.
module axi_pix_packer #(
   parameter int IDSIZE = 24,
   parameter int ODSIZE = 256
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                clear,
   input  logic                iwr_en,
   input  logic [IDSIZE-1:0]   idata,
   input  logic                ilast,
   output logic                iready,
   output logic                owr_en,
   input  logic                oready,
   output logic [ODSIZE-1:0]   odata,
   output logic [ODSIZE/8-1:0] ostrb,
   output logic                olast
);
   localparam int SW = ODSIZE / 8;
   localparam int PW = $clog2(ODSIZE) + 1;
   localparam logic [PW-1:0] OD_P = PW'(ODSIZE);
   localparam logic [PW-1:0] ID_P = PW'(IDSIZE);

   generate
      if (IDSIZE < 1 || IDSIZE > ODSIZE || (ODSIZE % 8) != 0) begin : g_bad_param
         $fatal(1, "axi_pix_packer: illegal IDSIZE/ODSIZE combination");
      end
   endgenerate

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [ODSIZE-1:0] r_acc;
   logic [ODSIZE-1:0] r_odata;
   logic [SW-1:0]     r_ostrb;
   logic              r_olast;
   logic              r_owr_en;

   logic                w_out_free;
   logic                w_accept;
   logic [PW-1:0]       w_sum;
   logic [PW-1:0]       w_rem;
   logic [2*ODSIZE-1:0] w_merged;

   // Strobe for a partial word: one bit per byte touched by the first nbits bits.
   function automatic logic [SW-1:0] f_strb(input logic [PW-1:0] nbits);
      logic [SW-1:0] s;
      for (int i = 0; i < SW; i++) s[i] = (int'(nbits) > 8 * i);
      return s;
   endfunction

   assign w_out_free = !r_owr_en || oready;
   assign iready     = (r_state == RUN) && w_out_free;
   assign w_accept   = iwr_en && iready;
   assign w_sum      = r_ptr + ID_P;
   assign w_rem      = w_sum - OD_P;
   // Upper half holds the part of a straddling pixel that spills into the next word.
   assign w_merged   = {{ODSIZE{1'b0}}, r_acc} |
                       ({{(2*ODSIZE-IDSIZE){1'b0}}, idata} << r_ptr);

   assign owr_en = r_owr_en;
   assign odata  = r_odata;
   assign ostrb  = r_ostrb;
   assign olast  = r_olast;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state  <= RUN;
         r_ptr    <= '0;
         r_acc    <= '0;
         r_odata  <= '0;
         r_ostrb  <= '0;
         r_olast  <= 1'b0;
         r_owr_en <= 1'b0;
      end else if (clear) begin
         r_state  <= RUN;
         r_ptr    <= '0;
         r_acc    <= '0;
         r_odata  <= '0;
         r_ostrb  <= '0;
         r_olast  <= 1'b0;
         r_owr_en <= 1'b0;
      end else begin
         if (oready) r_owr_en <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_accept) begin
                  if (w_sum < OD_P) begin
                     if (ilast) begin
                        r_odata  <= w_merged[ODSIZE-1:0];
                        r_ostrb  <= f_strb(w_sum);
                        r_olast  <= 1'b1;
                        r_owr_en <= 1'b1;
                        r_ptr    <= '0;
                        r_acc    <= '0;
                     end else begin
                        r_acc <= w_merged[ODSIZE-1:0];
                        r_ptr <= w_sum;
                     end
                  end else begin
                     r_odata  <= w_merged[ODSIZE-1:0];
                     r_ostrb  <= '1;
                     r_owr_en <= 1'b1;
                     if (w_sum == OD_P) begin
                        r_olast <= ilast;
                        r_ptr   <= '0;
                        r_acc   <= '0;
                     end else begin
                        r_olast <= 1'b0;
                        r_acc   <= w_merged[2*ODSIZE-1:ODSIZE];
                        r_ptr   <= w_rem;
                        if (ilast) r_state <= FLUSH;
                     end
                  end
               end
            end
            FLUSH: begin
               if (w_out_free) begin
                  r_odata  <= r_acc;
                  r_ostrb  <= f_strb(r_ptr);
                  r_olast  <= 1'b1;
                  r_owr_en <= 1'b1;
                  r_ptr    <= '0;
                  r_acc    <= '0;
                  r_state  <= RUN;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_pix_packer.sv
// Directed bench for axi_pix_packer: a 24-bit and a 32-bit instance packing into 256-bit
// words, covering straddling, FLUSH, backpressure, back-to-back emits, rst and clear.
`timescale 1ns/1ps
module tb_axi_pix_packer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         clear24, iwr24, ilast24, irdy24, owr24, ordy24, ol24;
   logic [23:0]  idata24;
   logic [255:0] od24;
   logic [31:0]  os24;
   logic         clear32, iwr32, ilast32, irdy32, owr32, ordy32, ol32;
   logic [31:0]  idata32;
   logic [255:0] od32;
   logic [31:0]  os32;

   axi_pix_packer #(.IDSIZE(24), .ODSIZE(256)) dut24 (
      .clock(clk), .rst(rst), .clear(clear24), .iwr_en(iwr24), .idata(idata24),
      .ilast(ilast24), .iready(irdy24), .owr_en(owr24), .oready(ordy24),
      .odata(od24), .ostrb(os24), .olast(ol24));

   axi_pix_packer #(.IDSIZE(32), .ODSIZE(256)) dut32 (
      .clock(clk), .rst(rst), .clear(clear32), .iwr_en(iwr32), .idata(idata32),
      .ilast(ilast32), .iready(irdy32), .owr_en(owr32), .oready(ordy32),
      .odata(od32), .ostrb(os32), .olast(ol32));

   int n_chk = 0;
   int n_pass = 0;

   logic [255:0] q24_d[$];
   logic [31:0]  q24_s[$];
   logic         q24_l[$];
   logic [255:0] q32_d[$];
   logic [31:0]  q32_s[$];
   logic         q32_l[$];

   int           low24, low32, hi32, chg24, stall_left;
   logic         stall_arm, hold24, have_held, s_rdy24, s_rdy32;
   logic [255:0] held;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   // Word w of a 24-bit pixel stream whose pixel i has value base+i.
   function automatic logic [255:0] exp24(input int w, input int base);
      logic [255:0] r;
      logic [23:0]  p;
      int           g;
      for (int b = 0; b < 256; b++) begin
         g    = w * 256 + b;
         p    = 24'(g / 24 + base);
         r[b] = p[g % 24];
      end
      return r;
   endfunction

   // One clock: entered and left at posedge+1; samples at the falling edge.
   task tick();
      if (stall_arm && owr24) begin
         stall_arm  = 1'b0;
         stall_left = 5;
      end
      ordy24 = !(stall_left > 0 || hold24);
      if (stall_left > 0) stall_left--;
      #4;
      if (!rst) begin
         if (owr24 && ordy24) begin
            q24_d.push_back(od24); q24_s.push_back(os24); q24_l.push_back(ol24);
         end
         if (owr32 && ordy32) begin
            q32_d.push_back(od32); q32_s.push_back(os32); q32_l.push_back(ol32);
         end
         if (!irdy24) low24++;
         if (!irdy32) low32++;
         if (owr32) hi32++;
         if (owr24 && !ordy24) begin
            if (have_held && od24 !== held) chg24++;
            held      = od24;
            have_held = 1'b1;
         end
      end
      s_rdy24 = irdy24;
      s_rdy32 = irdy32;
      @(posedge clk);
      #1;
   endtask

   task automatic push24(input logic [23:0] px, input logic last);
      int tries = 0;
      iwr24 = 1'b1; idata24 = px; ilast24 = last;
      do begin tick(); tries++; end while (!s_rdy24 && tries < 40);
      if (!s_rdy24) chk("push24_timeout", 256'(s_rdy24), 256'(1));
      iwr24 = 1'b0; ilast24 = 1'b0;
   endtask

   task automatic push32(input logic [31:0] px, input logic last);
      int tries = 0;
      iwr32 = 1'b1; idata32 = px; ilast32 = last;
      do begin tick(); tries++; end while (!s_rdy32 && tries < 40);
      if (!s_rdy32) chk("push32_timeout", 256'(s_rdy32), 256'(1));
      iwr32 = 1'b0; ilast32 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] e;
      logic [255:0] w;
      rst = 1'b1; clear24 = 0; clear32 = 0;
      iwr24 = 0; ilast24 = 0; idata24 = '0; ordy24 = 1;
      iwr32 = 0; ilast32 = 0; idata32 = '0; ordy32 = 1;
      low24 = 0; low32 = 0; hi32 = 0; chg24 = 0; stall_left = 0;
      stall_arm = 0; hold24 = 0; have_held = 0; s_rdy24 = 0; s_rdy32 = 0; held = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #4;
      chk("rst_owr_en", 256'(owr24), 256'(0));
      chk("rst_odata", od24, 256'(0));
      chk("rst_ostrb", 256'(os24), 256'(0));
      chk("rst_olast", 256'(ol24), 256'(0));
      chk("rst_iready", 256'(irdy24), 256'(1));
      chk("rst_owr_en32", 256'(owr32), 256'(0));
      @(posedge clk);
      #1;

      // 24-bit pixels 0..31, no ilast: exactly three full words
      low24 = 0;
      for (int k = 0; k < 32; k++) push24(24'(k), 1'b0);
      repeat (3) tick();
      chk("t1_nwords", 256'(q24_d.size()), 256'(3));
      if (q24_d.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_w%0d_data", i), q24_d[i], exp24(i, 0));
            chk($sformatf("t1_w%0d_strb", i), 256'(q24_s[i]), 256'(32'hFFFF_FFFF));
            chk($sformatf("t1_w%0d_last", i), 256'(q24_l[i]), 256'(0));
         end
         w = q24_d[0];
         chk("t1_w0_lo", 256'(w[23:0]), 256'(0));
         chk("t1_w0_hi", 256'(w[255:240]), 256'(16'd10));
         w = q24_d[2];
         chk("t1_w2_hi", 256'(w[255:232]), 256'(24'd31));
      end
      chk("t1_ptr", 256'(dut24.r_ptr), 256'(0));
      chk("t1_no_stall", 256'(low24), 256'(0));

      // 24-bit pixels 1..11, ilast on 11th: overflow then FLUSH
      q24_d.delete(); q24_s.delete(); q24_l.delete();
      low24 = 0;
      for (int k = 1; k <= 11; k++) push24(24'(k), k == 11);
      repeat (4) tick();
      chk("t2_nwords", 256'(q24_d.size()), 256'(2));
      if (q24_d.size() == 2) begin
         chk("t2_w0_data", q24_d[0], exp24(0, 1));
         chk("t2_w0_strb", 256'(q24_s[0]), 256'(32'hFFFF_FFFF));
         chk("t2_w0_last", 256'(q24_l[0]), 256'(0));
         chk("t2_w1_data", q24_d[1], 256'(0));
         chk("t2_w1_strb", 256'(q24_s[1]), 256'(32'h0000_0001));
         chk("t2_w1_last", 256'(q24_l[1]), 256'(1));
      end
      chk("t2_iready_low", 256'(low24), 256'(1));

      // 32-bit, 8 pixels with ilast on the 8th: exact fit, no FLUSH
      low32 = 0;
      e = '0;
      for (int k = 0; k < 8; k++) begin
         push32(32'hA500_0000 + 32'(k), k == 7);
         e[32*k +: 32] = 32'hA500_0000 + 32'(k);
      end
      repeat (3) tick();
      chk("t3_nwords", 256'(q32_d.size()), 256'(1));
      if (q32_d.size() == 1) begin
         chk("t3_data", q32_d[0], e);
         chk("t3_strb", 256'(q32_s[0]), 256'(32'hFFFF_FFFF));
         chk("t3_last", 256'(q32_l[0]), 256'(1));
      end
      chk("t3_no_flush", 256'(low32), 256'(0));

      // 32-bit, 3 pixels with ilast: partial word
      q32_d.delete(); q32_s.delete(); q32_l.delete();
      e = '0;
      for (int k = 0; k < 3; k++) begin
         push32(32'h1111_1111 * 32'(k + 1), k == 2);
         e[32*k +: 32] = 32'h1111_1111 * 32'(k + 1);
      end
      repeat (3) tick();
      chk("t3p_nwords", 256'(q32_d.size()), 256'(1));
      if (q32_d.size() == 1) begin
         w = q32_d[0];
         chk("t3p_data", w, e);
         chk("t3p_upper0", 256'(w[255:96]), 256'(0));
         chk("t3p_strb", 256'(q32_s[0]), 256'(32'h0000_0FFF));
         chk("t3p_last", 256'(q32_l[0]), 256'(1));
      end

      // One-pixel lines back to back: emit coincides with oready every cycle
      q32_d.delete(); q32_s.delete(); q32_l.delete();
      hi32 = 0;
      for (int k = 0; k < 4; k++) push32(32'hC0DE_0000 + 32'(k), 1'b1);
      repeat (3) tick();
      chk("t5_nwords", 256'(q32_d.size()), 256'(4));
      if (q32_d.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_w%0d_data", i), q32_d[i], 256'(32'hC0DE_0000 + 32'(i)));
            chk($sformatf("t5_w%0d_strb", i), 256'(q32_s[i]), 256'(32'h0000_000F));
            chk($sformatf("t5_w%0d_last", i), 256'(q32_l[i]), 256'(1));
         end
      end
      chk("t5_owr_hi_cycles", 256'(hi32), 256'(4));

      // Backpressure: oready low for 5 cycles once the first word appears
      q24_d.delete(); q24_s.delete(); q24_l.delete();
      low24 = 0; chg24 = 0; have_held = 0; stall_arm = 1;
      for (int k = 0; k < 32; k++) push24(24'(100 + k), 1'b0);
      repeat (3) tick();
      chk("t4_nwords", 256'(q24_d.size()), 256'(3));
      if (q24_d.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_w%0d_data", i), q24_d[i], exp24(i, 100));
            chk($sformatf("t4_w%0d_strb", i), 256'(q24_s[i]), 256'(32'hFFFF_FFFF));
         end
      end
      chk("t4_iready_low", 256'(low24), 256'(5));
      chk("t4_held_stable", 256'(chg24), 256'(0));

      // rst mid-line at ptr=16
      for (int k = 0; k < 22; k++) push24(24'(k), 1'b0);
      chk("t6_pre_rst_ptr", 256'(dut24.r_ptr), 256'(16));
      rst = 1'b1;
      #1;
      chk("t6_rst_owr_en", 256'(owr24), 256'(0));
      chk("t6_rst_odata", od24, 256'(0));
      chk("t6_rst_ostrb", 256'(os24), 256'(0));
      chk("t6_rst_olast", 256'(ol24), 256'(0));
      chk("t6_rst_ptr", 256'(dut24.r_ptr), 256'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      q24_d.delete(); q24_s.delete(); q24_l.delete();
      push24(24'h000001, 1'b0);
      push24(24'h000002, 1'b1);
      repeat (3) tick();
      chk("t6_rst_nwords", 256'(q24_d.size()), 256'(1));
      if (q24_d.size() == 1) begin
         chk("t6_rst_data", q24_d[0], 256'({24'h000002, 24'h000001}));
         chk("t6_rst_strb", 256'(q24_s[0]), 256'(32'h0000_003F));
         chk("t6_rst_last", 256'(q24_l[0]), 256'(1));
      end

      // clear while FLUSH is stalled behind an unaccepted word
      q24_d.delete(); q24_s.delete(); q24_l.delete();
      hold24 = 1'b1;
      for (int k = 1; k <= 11; k++) push24(24'(k), k == 11);
      repeat (2) tick();
      chk("t7_flush_stall_irdy", 256'(irdy24), 256'(0));
      chk("t7_flush_stall_owr", 256'(owr24), 256'(1));
      clear24 = 1'b1;
      tick();
      clear24 = 1'b0;
      chk("t7_clr_owr_en", 256'(owr24), 256'(0));
      chk("t7_clr_olast", 256'(ol24), 256'(0));
      chk("t7_clr_odata", od24, 256'(0));
      chk("t7_clr_iready", 256'(irdy24), 256'(1));
      hold24 = 1'b0;
      repeat (3) tick();
      chk("t7_no_residue", 256'(q24_d.size()), 256'(0));
      push24(24'h000005, 1'b0);
      push24(24'h000006, 1'b1);
      repeat (3) tick();
      chk("t7_nwords", 256'(q24_d.size()), 256'(1));
      if (q24_d.size() == 1) begin
         chk("t7_data", q24_d[0], 256'({24'h000006, 24'h000005}));
         chk("t7_strb", 256'(q24_s[0]), 256'(32'h0000_003F));
         chk("t7_last", 256'(q24_l[0]), 256'(1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
